// File: rtl/forth_pkg.sv
// Shared constants and state encoding for the Forth CPU memory block.
package forth_pkg;
   localparam int WORD_W     = 16;
   localparam int IMEM_AW    = 10;
   localparam int DMEM_AW    = 8;
   localparam int IMEM_DEPTH = 1 << IMEM_AW;
   localparam logic [WORD_W-1:0] OP_NOP = 16'he040;

   typedef enum logic {
      ST_LOAD = 1'b0,
      ST_RUN  = 1'b1
   } state_e;
endpackage

// File: rtl/forth_ram.sv
// Simple RAM: one synchronous write port, one combinational read port.
module forth_ram
   import forth_pkg::*;
#(
   parameter int W  = WORD_W,
   parameter int AW = DMEM_AW
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   // No reset and no init: contents survive reset and start unspecified.
   logic [W-1:0] mem_q [2**AW];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/forth_mem.sv
// Instruction/data memory for the Forth CPU with an image loader that holds
// the CPU in reset until a program has been streamed into instruction memory.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_LOAD | accepting loader words into imem, CPU held in reset, idata=NOP
// ST_RUN  | CPU running, idata fetched from imem, loader ignored
module forth_mem
   import forth_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic [IMEM_AW-1:0]  iaddr,
   output logic [WORD_W-1:0]   idata,
   input  logic [DMEM_AW-1:0]  daddr,
   input  logic [WORD_W-1:0]   ddata_write,
   input  logic                dwrite,
   output logic [WORD_W-1:0]   ddata_read,
   input  logic                load_valid,
   input  logic [WORD_W-1:0]   load_data,
   input  logic                load_last,
   output logic                load_ready,
   input  logic                load_start,
   output logic                cpu_reset,
   output logic [IMEM_AW:0]    words_loaded,
   output logic                load_overflow
);

   state_e              state_q, state_d;
   logic [IMEM_AW-1:0]  ptr_q, ptr_d;
   logic [IMEM_AW:0]    wl_q, wl_d;
   logic                ovf_q, ovf_d;
   logic                cpu_reset_q;
   logic [WORD_W-1:0]   idata_q, idata_d;
   logic [WORD_W-1:0]   imem_rdata;
   logic                imem_we;

   forth_ram #(.W(WORD_W), .AW(IMEM_AW)) u_imem (
      .clk   (clk),
      .we    (imem_we),
      .waddr (ptr_q),
      .wdata (load_data),
      .raddr (iaddr),
      .rdata (imem_rdata)
   );

   forth_ram #(.W(WORD_W), .AW(DMEM_AW)) u_dmem (
      .clk   (clk),
      .we    (dwrite),
      .waddr (daddr),
      .wdata (ddata_write),
      .raddr (daddr),
      .rdata (ddata_read)
   );

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      wl_d    = wl_q;
      ovf_d   = ovf_q;
      imem_we = 1'b0;
      idata_d = (state_q == ST_RUN) ? imem_rdata : OP_NOP;

      if (state_q == ST_LOAD) begin
         // A restart request wins over a word offered in the same cycle.
         if (load_start) begin
            ptr_d = '0;
            wl_d  = '0;
            ovf_d = 1'b0;
         end else if (load_valid) begin
            imem_we = 1'b1;
            ptr_d   = ptr_q + 1'b1;
            wl_d    = wl_q + 1'b1;
            if (load_last) begin
               state_d = ST_RUN;
            end else if (ptr_q == {IMEM_AW{1'b1}}) begin
               state_d = ST_RUN;
               ovf_d   = 1'b1;
            end
         end
      end else begin
         if (load_start) begin
            state_d = ST_LOAD;
            ptr_d   = '0;
            wl_d    = '0;
            ovf_d   = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_LOAD;
         ptr_q       <= '0;
         wl_q        <= '0;
         ovf_q       <= 1'b0;
         cpu_reset_q <= 1'b1;
         idata_q     <= OP_NOP;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         wl_q        <= wl_d;
         ovf_q       <= ovf_d;
         cpu_reset_q <= (state_d == ST_LOAD);
         idata_q     <= idata_d;
      end
   end

   assign idata         = idata_q;
   assign cpu_reset     = cpu_reset_q;
   assign load_ready    = (state_q == ST_LOAD);
   assign words_loaded  = wl_q;
   assign load_overflow = ovf_q;

endmodule

// File: tb/tb_forth_mem.sv
// Randomized bench for forth_mem against an array-based reference model.
module tb_forth_mem;
   import forth_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [9:0]  iaddr = '0;
   logic [15:0] idata;
   logic [7:0]  daddr = '0;
   logic [15:0] ddata_write = '0;
   logic        dwrite = 1'b0;
   logic [15:0] ddata_read;
   logic        load_valid = 1'b0;
   logic [15:0] load_data = '0;
   logic        load_last = 1'b0;
   logic        load_ready;
   logic        load_start = 1'b0;
   logic        cpu_reset;
   logic [10:0] words_loaded;
   logic        load_overflow;

   forth_mem dut (
      .clk           (clk),
      .reset         (reset),
      .iaddr         (iaddr),
      .idata         (idata),
      .daddr         (daddr),
      .ddata_write   (ddata_write),
      .dwrite        (dwrite),
      .ddata_read    (ddata_read),
      .load_valid    (load_valid),
      .load_data     (load_data),
      .load_last     (load_last),
      .load_ready    (load_ready),
      .load_start    (load_start),
      .cpu_reset     (cpu_reset),
      .words_loaded  (words_loaded),
      .load_overflow (load_overflow)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: memory images with "has been written" flags, plus
   // loader status. The load address is simply the count of words taken.
   logic [15:0] im [1024];
   bit          ik [1024];
   logic [15:0] dm [256];
   bit          dk [256];
   bit          m_load = 1'b1;
   int          m_wl = 0;
   bit          m_ovf = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Inputs are already applied by the caller (just after an edge).
   task automatic cycle();
      logic [15:0] exp_i;
      bit          exp_ik;
      #1;
      check("load_ready", load_ready, m_load);
      if (dk[daddr]) check("ddata_read", ddata_read, dm[daddr]);
      exp_ik = 1'b1;
      exp_i  = OP_NOP;
      if (!m_load) begin
         if (ik[iaddr]) exp_i = im[iaddr];
         else exp_ik = 1'b0;
      end
      if (dwrite) begin
         dm[daddr] = ddata_write;
         dk[daddr] = 1'b1;
      end
      if (load_start) begin
         m_load = 1'b1;
         m_wl   = 0;
         m_ovf  = 1'b0;
      end else if (m_load && load_valid) begin
         im[m_wl] = load_data;
         ik[m_wl] = 1'b1;
         m_wl++;
         if (load_last) m_load = 1'b0;
         else if (m_wl == 1024) begin
            m_load = 1'b0;
            m_ovf  = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      if (exp_ik) check("idata", idata, exp_i);
      check("cpu_reset", cpu_reset, m_load);
      check("words_loaded", words_loaded, m_wl);
      check("load_overflow", load_overflow, m_ovf);
   endtask

   task automatic do_reset();
      load_valid = 1'b0;
      load_start = 1'b0;
      load_last  = 1'b0;
      dwrite     = 1'b0;
      reset      = 1'b1;
      #1;
      check("rst_idata", idata, OP_NOP);
      check("rst_cpu_reset", cpu_reset, 1);
      check("rst_load_ready", load_ready, 1);
      check("rst_words_loaded", words_loaded, 0);
      check("rst_load_overflow", load_overflow, 0);
      @(posedge clk);
      #1;
      reset  = 1'b0;
      m_load = 1'b1;
      m_wl   = 0;
      m_ovf  = 1'b0;
   endtask

   task automatic load_word(input logic [15:0] d, input bit last);
      load_valid = 1'b1;
      load_data  = d;
      load_last  = last;
      cycle();
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   task automatic pulse_start();
      load_start = 1'b1;
      cycle();
      load_start = 1'b0;
   endtask

   task automatic run_random(input int n, input int imax);
      for (int i = 0; i < n; i++) begin
         iaddr       = 10'($urandom_range(0, imax));
         daddr       = 8'($urandom);
         ddata_write = 16'($urandom);
         dwrite      = ($urandom_range(0, 1) == 1);
         load_valid  = ($urandom_range(0, 3) == 0);
         load_data   = 16'($urandom);
         cycle();
      end
      dwrite     = 1'b0;
      load_valid = 1'b0;
   endtask

   logic [15:0] saved [5];

   initial begin
      #2;
      do_reset();

      iaddr = '0;
      for (int i = 0; i < 3; i++) cycle();
      load_word(16'h0001, 1'b0);
      load_word(16'h0002, 1'b0);
      load_word(16'he007, 1'b1);
      check("req035_words", words_loaded, 3);
      check("req035_cpu_reset", cpu_reset, 0);
      iaddr = 10'd2;
      cycle();
      check("req035_idata", idata, 16'he007);

      run_random(200, 2);

      daddr = 8'h10; ddata_write = 16'h1234; dwrite = 1'b1;
      cycle();
      dwrite = 1'b0;
      for (int a = 8'h0e; a <= 8'h12; a++) begin
         daddr = 8'(a);
         cycle();
      end
      daddr = 8'h10;
      #1;
      check("req038_ddata", ddata_read, 16'h1234);
      cycle();

      pulse_start();
      begin
         int n;
         n = $urandom_range(6, 40);
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) cycle();
            if (i == 3) begin
               load_start = 1'b1;
               load_word(16'($urandom), 1'b0);
               load_start = 1'b0;
               check("req040_words", words_loaded, 0);
            end
            load_word(16'($urandom), i == n - 1);
         end
         run_random(100, n - 1);
      end

      pulse_start();
      for (int i = 0; i < 1024; i++) begin
         if ($urandom_range(0, 15) == 0) cycle();
         iaddr = 10'($urandom);
         load_word(16'($urandom), 1'b0);
      end
      check("req037_words", words_loaded, 1024);
      check("req037_overflow", load_overflow, 1);
      check("req037_cpu_reset", cpu_reset, 0);
      run_random(100, 1023);
      pulse_start();
      check("req037_ovf_clear", load_overflow, 0);

      for (int i = 0; i < 5; i++) begin
         saved[i] = 16'($urandom);
         load_word(saved[i], 1'b0);
      end
      cycle();
      do_reset();
      load_word(16'hAAAA, 1'b0);
      load_word(16'hBBBB, 1'b1);
      for (int a = 0; a < 5; a++) begin
         iaddr = 10'(a);
         cycle();
         case (a)
            0: check("req039_imem0", idata, 16'hAAAA);
            1: check("req039_imem1", idata, 16'hBBBB);
            default: check("req039_imem_keep", idata, saved[a]);
         endcase
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/forth_mem.md
FORTH_MEM -- requirements
Module: forth_mem

Interface
REQ-001 clk  input  1  single clock; all state changes on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 iaddr  input  10  CPU instruction fetch address (word).
REQ-004 idata  output  16  registered instruction word returned to CPU.
REQ-005 daddr  input  8  CPU data address (word).
REQ-006 ddata_write  input  16  CPU store data.
REQ-007 dwrite  input  1  CPU store strobe; write on the rising edge where high.
REQ-008 ddata_read  output  16  data word at daddr, combinational read.
REQ-009 load_valid  input  1  loader word valid.
REQ-010 load_data  input  16  loader instruction word.
REQ-011 load_last  input  1  qualifies final word of image; sampled with load_valid.
REQ-012 load_ready  output  1  block accepts a loader word this cycle.
REQ-013 load_start  input  1  one-cycle request to reload the image.
REQ-014 cpu_reset  output  1  holds the CPU in reset while loading.
REQ-015 words_loaded  output  11  count of words accepted in current/last load, 0..1024.
REQ-016 load_overflow  output  1  sticky: image filled all 1024 words without load_last.

Function
REQ-017 Instruction memory SHALL be 1024x16; data memory SHALL be 256x16.
REQ-018 idata SHALL be updated on every rising edge to imem[iaddr] sampled at that edge (1-cycle fetch latency) while in RUN.
REQ-019 In LOAD, idata SHALL be registered to OP_NOP (16'he040) regardless of iaddr.
REQ-020 ddata_read SHALL equal dmem[daddr] combinationally; a store appears on ddata_read the cycle after the write edge.
REQ-021 dwrite SHALL be honoured in every state; same-address write and read in one cycle returns old data until the edge.
REQ-022 FSM states SHALL be LOAD and RUN only.
REQ-023 LOAD: load_ready=1, cpu_reset=1; each cycle with load_valid=1 SHALL write load_data to imem[ptr], increment ptr and words_loaded.
REQ-024 LOAD -> RUN on the edge accepting a word with load_last=1, or accepting the word at ptr=1023 (then load_overflow SHALL set unless load_last=1 on that word).
REQ-025 RUN: load_ready=0, cpu_reset=0; load_valid SHALL be ignored.
REQ-026 RUN -> LOAD on load_start=1: ptr, words_loaded, load_overflow cleared on that edge.
REQ-027 load_start in LOAD SHALL restart the load (ptr=0, words_loaded=0), taking priority over a simultaneous load_valid word.
REQ-028 cpu_reset SHALL be a registered output with no combinational path from inputs.
REQ-029 Memory contents not yet written SHALL be unspecified; no zero-fill.

Reset
REQ-030 reset SHALL force: state=LOAD, ptr=0, words_loaded=0, load_overflow=0, cpu_reset=1, load_ready=1, idata=16'he040.
REQ-031 Reset SHALL NOT clear imem or dmem contents.
REQ-032 Reset asserted mid-load SHALL abandon the partial image; subsequent loader words start at address 0.

Structure
REQ-033 Shared package forth_pkg SHALL hold OP_NOP, IMEM_AW=10, DMEM_AW=8, word width 16, and the LOAD/RUN state enum.
REQ-034 One sub-module forth_ram (parameterised width/depth, one write port, one read port) SHALL be instantiated for both memories.

Verification
REQ-035 Reset, stream 1,2,'he007 with load_last on third -> words_loaded=3, RUN next cycle, cpu_reset=0, iaddr=2 yields idata='he007 one edge later.
REQ-036 During LOAD, iaddr=0 -> idata='he040 each cycle; load_ready=1.
REQ-037 Stream 1024 words, no load_last -> RUN after 1024th, words_loaded=1024, load_overflow=1; load_start clears it.
REQ-038 RUN, dwrite=1 daddr=8'h10 ddata_write='h1234 -> next cycle ddata_read='h1234 at daddr='h10; other addresses unchanged.
REQ-039 Assert reset after 5 words loaded, reload 2 words 'hAAAA,'hBBBB -> imem[0..1] new, imem[2..4] retain old.
REQ-040 load_start and load_valid same cycle in LOAD -> word discarded, words_loaded=0.
